ula_datapath: RTL and testbench

- Small 4-bit arithmetic datapath for a board-level demo processor.
- Two 4-bit general-purpose operand registers (A, B) load from a shared operand input.
- A clocked ULA (ALU) computes an 8-bit result from A and B under a 4-bit opcode.
- The result is presented in binary and as three decimal digits on active-low 7-segment displays.

---
 rtl/ula_datapath.sv | 129 ++++++++++++
 tb/tb_ula_datapath.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ula_datapath.sv
// rtl/ula_datapath.sv - 4-bit operand registers, clocked ULA and 3-digit 7-segment display
//
// Purpose:
//   Two 4-bit operand registers (A, B) load from a shared operand bus. A
//   registered ULA computes an 8-bit result under a 4-bit opcode. The result
//   is shown as three decimal digits on active-low 7-segment displays.
//
// Ports:
//   clock          in   1  system clock, rising edge
//   reset          in   1  synchronous, active-high reset
//   setRegA        in   1  load enable for A
//   setRegB        in   1  load enable for B
//   operando       in   4  operand data shared by A and B
//   latch_ula      in   1  capture a new ULA result
//   ula_operation  in   4  opcode
//   result         out  8  registered ULA result
//   HEX0           out  8  units digit (active-low segments, bit0=a .. bit6=g, bit7=dp)
//   HEX1           out  8  tens digit
//   HEX2           out  8  hundreds digit
//   HEX3           out  8  unused display, always blank
//
// Optional feature:
//   LEADING_ZERO_BLANK_EN - blank leading zero digits on HEX2/HEX1.

module ula_datapath (
  input  logic       clock,
  input  logic       reset,
  input  logic       setRegA,
  input  logic       setRegB,
  input  logic [3:0] operando,
  input  logic       latch_ula,
  input  logic [3:0] ula_operation,
  output logic [7:0] result,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3
);

  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [7:0] result_q, result_d;
  logic [7:0] alu_val;

  logic [7:0] a_ext, b_ext;
  assign a_ext = {4'b0000, a_q};
  assign b_ext = {4'b0000, b_q};

  // ULA operates on register values before the edge, so a same-edge load
  // of A/B only becomes visible to the following latch.
  always_comb begin
    alu_val = 8'h00;
    case (ula_operation)
      4'd0:  alu_val = a_ext + b_ext;
      4'd1:  alu_val = a_ext - b_ext;
      4'd2:  alu_val = a_ext * b_ext;
      4'd3:  alu_val = (b_q == 4'd0) ? 8'h00 : (a_ext / b_ext);
      4'd4:  alu_val = (b_q == 4'd0) ? 8'h00 : (a_ext % b_ext);
      4'd5:  alu_val = {4'b0000, a_q & b_q};
      4'd6:  alu_val = {4'b0000, a_q | b_q};
      4'd7:  alu_val = {4'b0000, a_q ^ b_q};
      4'd8:  alu_val = {4'b0000, ~a_q};
      4'd9:  alu_val = {3'b000, a_q, 1'b0};
      4'd10: alu_val = {5'b00000, a_q[3:1]};
      4'd11: alu_val = a_ext;
      4'd12: alu_val = b_ext;
      4'd13: alu_val = (a_q == b_q) ? 8'h01 : 8'h00;
      4'd14: alu_val = (a_q >  b_q) ? 8'h01 : 8'h00;
      4'd15: alu_val = (a_q <  b_q) ? 8'h01 : 8'h00;
      default: alu_val = 8'h00;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    if (setRegA)   a_d      = operando;
    if (setRegB)   b_d      = operando;
    if (latch_ula) result_d = alu_val;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      result_q <= 8'd0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

  // Decoder takes a full byte so any value above 9 blanks the display.
  function automatic logic [7:0] seg7(input logic [7:0] d);
    case (d)
      8'd0:    seg7 = 8'hC0;
      8'd1:    seg7 = 8'hF9;
      8'd2:    seg7 = 8'hA4;
      8'd3:    seg7 = 8'hB0;
      8'd4:    seg7 = 8'h99;
      8'd5:    seg7 = 8'h92;
      8'd6:    seg7 = 8'h82;
      8'd7:    seg7 = 8'hF8;
      8'd8:    seg7 = 8'h80;
      8'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  logic [7:0] units, tens, hundreds;
  assign units    = result_q % 8'd10;
  assign tens     = (result_q / 8'd10) % 8'd10;
  assign hundreds = result_q / 8'd100;

  assign HEX0 = seg7(units);
`ifdef LEADING_ZERO_BLANK_EN
  assign HEX2 = (hundreds == 8'd0) ? 8'hFF : seg7(hundreds);
  assign HEX1 = ((hundreds == 8'd0) && (tens == 8'd0)) ? 8'hFF : seg7(tens);
`else
  assign HEX2 = seg7(hundreds);
  assign HEX1 = seg7(tens);
`endif
  assign HEX3 = 8'hFF;

endmodule

// File: tb/tb_ula_datapath.sv
// tb/tb_ula_datapath.sv - directed self-checking bench for ula_datapath

module tb_ula_datapath;

  logic       clock = 1'b0;
  logic       reset;
  logic       setRegA;
  logic       setRegB;
  logic [3:0] operando;
  logic       latch_ula;
  logic [3:0] ula_operation;
  logic [7:0] result;
  logic [7:0] HEX0, HEX1, HEX2, HEX3;

  int errors = 0;
  int checks = 0;

  ula_datapath dut (
    .clock        (clock),
    .reset        (reset),
    .setRegA      (setRegA),
    .setRegB      (setRegB),
    .operando     (operando),
    .latch_ula    (latch_ula),
    .ula_operation(ula_operation),
    .result       (result),
    .HEX0         (HEX0),
    .HEX1         (HEX1),
    .HEX2         (HEX2),
    .HEX3         (HEX3)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_a(input logic [3:0] v);
    setRegA = 1'b1; operando = v;
    step();
    setRegA = 1'b0;
  endtask

  task automatic load_b(input logic [3:0] v);
    setRegB = 1'b1; operando = v;
    step();
    setRegB = 1'b0;
  endtask

  task automatic exec(input string tag, input logic [3:0] op, input logic [7:0] exp);
    latch_ula = 1'b1; ula_operation = op;
    step();
    latch_ula = 1'b0;
    check(tag, result, exp);
  endtask

  initial begin
    reset = 1'b1; setRegA = 1'b1; setRegB = 1'b1; operando = 4'd5;
    latch_ula = 1'b1; ula_operation = 4'd0;
    step();
    reset = 1'b0; setRegA = 1'b0; setRegB = 1'b0; latch_ula = 1'b0;
    check("rst_result", result, 8'd0);
    check("rst_hex0", HEX0, 8'hC0);
`ifdef LEADING_ZERO_BLANK_EN
    check("rst_hex1", HEX1, 8'hFF);
    check("rst_hex2", HEX2, 8'hFF);
`else
    check("rst_hex1", HEX1, 8'hC0);
    check("rst_hex2", HEX2, 8'hC0);
`endif
    check("rst_hex3", HEX3, 8'hFF);
    exec("rst_a_b_add", 4'd0, 8'd0);

    load_a(4'd9);
    load_b(4'd7);
    exec("add_9_7", 4'd0, 8'd16);
    check("add_hex0", HEX0, 8'h82);
    check("add_hex1", HEX1, 8'hF9);
`ifdef LEADING_ZERO_BLANK_EN
    check("add_hex2", HEX2, 8'hFF);
`else
    check("add_hex2", HEX2, 8'hC0);
`endif

    setRegA = 1'b1; setRegB = 1'b1; operando = 4'd15;
    step();
    setRegA = 1'b0; setRegB = 1'b0;
    exec("mul_15_15", 4'd2, 8'd225);
    check("mul_hex2", HEX2, 8'hA4);
    check("mul_hex1", HEX1, 8'hA4);
    check("mul_hex0", HEX0, 8'h92);

    load_b(4'd4);
    exec("div_15_4", 4'd3, 8'd3);
    exec("mod_15_4", 4'd4, 8'd3);

    load_a(4'd3);
    load_b(4'd5);
    exec("sub_3_5", 4'd1, 8'd254);
    check("sub_hex2", HEX2, 8'hA4);
    check("sub_hex1", HEX1, 8'h92);
    check("sub_hex0", HEX0, 8'h99);
    load_b(4'd0);
    exec("div_by_0", 4'd3, 8'd0);
    exec("add_3_0", 4'd0, 8'd3);
    exec("mod_by_0", 4'd4, 8'd0);

    load_a(4'd2);
    load_b(4'd3);
    setRegA = 1'b1; operando = 4'd8; latch_ula = 1'b1; ula_operation = 4'd0;
    step();
    setRegA = 1'b0; latch_ula = 1'b0;
    check("same_edge_old", result, 8'd5);
    exec("same_edge_new", 4'd0, 8'd11);
    load_a(4'd1);
    load_b(4'd4);
    check("hold_result", result, 8'd11);
    exec("after_hold", 4'd0, 8'd5);
    check("five_hex0", HEX0, 8'h92);
`ifdef LEADING_ZERO_BLANK_EN
    check("five_hex1", HEX1, 8'hFF);
`else
    check("five_hex1", HEX1, 8'hC0);
`endif

    load_a(4'd10);
    load_b(4'd12);
    exec("and", 4'd5, 8'd8);
    exec("or", 4'd6, 8'd14);
    exec("xor", 4'd7, 8'd6);
    exec("not", 4'd8, 8'd5);
    exec("shl", 4'd9, 8'd20);
    exec("shr", 4'd10, 8'd5);
    exec("passa", 4'd11, 8'd10);
    exec("passb", 4'd12, 8'd12);
    exec("eq_ne", 4'd13, 8'd0);
    exec("gt_no", 4'd14, 8'd0);
    exec("lt_yes", 4'd15, 8'd1);
    load_b(4'd10);
    exec("eq_yes", 4'd13, 8'd1);
    load_a(4'd15);
    exec("gt_yes", 4'd14, 8'd1);
    exec("lt_no", 4'd15, 8'd0);
    exec("shl_max", 4'd9, 8'd30);

    reset = 1'b1; setRegA = 1'b1; setRegB = 1'b1; latch_ula = 1'b1;
    step();
    reset = 1'b0; setRegA = 1'b0; setRegB = 1'b0; latch_ula = 1'b0;
    check("rst2_result", result, 8'd0);
    check("rst2_hex3", HEX3, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
